// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, the message-schedule FSM states and the
// small sigma functions used by both the schedule and the compression core.
package sha256_pkg;

    localparam int WORD_W        = 32;
    localparam int BLOCK_W       = 512;
    localparam int WINDOW        = 16;
    localparam int SHA256_ROUNDS = 64;

    typedef enum logic [0:0] {
        SCHED_IDLE,
        SCHED_RUN
    } sched_state_e;

    // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] sha256_sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] sha256_sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Next schedule word W[t+16] from the current window taps; kept combinational
// and standalone so a pipeline register can be inserted here later.
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w_t,
    input  logic [WORD_W-1:0] w_t1,
    input  logic [WORD_W-1:0] w_t9,
    input  logic [WORD_W-1:0] w_t14,
    output logic [WORD_W-1:0] w_next
);

    // Carries out of bit 31 fall off naturally at the 32-bit result width.
    assign w_next = sha256_sigma1(w_t14) + w_t9 + sha256_sigma0(w_t1) + w_t;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: takes one 512-bit block and streams W[0..NUM_ROUNDS-1]
// out of a 16-word sliding window, one word per accepted beat.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = SHA256_ROUNDS
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic                block_valid,
    input  logic [BLOCK_W-1:0]  block_data,
    output logic                block_ready,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [WORD_W-1:0]   w_data,
    output logic [5:0]          w_index,
    output logic                w_last,
    output logic                sched_done,
    output sched_state_e        sched_state
);

    localparam int              IDX_W  = $clog2(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] LAST_T = IDX_W'(NUM_ROUNDS - 1);

    sched_state_e      state_q;
    sched_state_e      state_d;
    logic [WORD_W-1:0] window_q [WINDOW];
    logic [WORD_W-1:0] w_next;
    logic [IDX_W-1:0]  t_q;
    logic              sched_done_q;
    logic              load;
    logic              beat;
    logic              last_beat;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high. block_ready/w_valid depend only on state, never on the
    // partner's valid/ready, and w_data/w_index hold while w_valid && !w_ready.
    assign block_ready = (state_q == SCHED_IDLE);
    assign w_valid     = (state_q == SCHED_RUN);
    assign w_data      = window_q[0];
    assign w_index     = 6'(t_q);
    assign w_last      = (state_q == SCHED_RUN) && (t_q == LAST_T);
    assign sched_done  = sched_done_q;
    assign sched_state = state_q;
    assign last_beat   = beat && (t_q == LAST_T);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SCHED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        beat    = 1'b0;
        case (state_q)
            SCHED_IDLE: begin
                if (block_valid) begin
                    load    = 1'b1;
                    state_d = SCHED_RUN;
                end
            end
            SCHED_RUN: begin
                if (w_ready) begin
                    beat = 1'b1;
                    if (t_q == LAST_T) begin
                        state_d = SCHED_IDLE;
                    end
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    sha256_w_next u_w_next (
        .w_t    (window_q[0]),
        .w_t1   (window_q[1]),
        .w_t9   (window_q[9]),
        .w_t14  (window_q[14]),
        .w_next (w_next)
    );

    // t saturates at the last index so it never wraps before the next load.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < WINDOW; k++) begin
                window_q[k] <= '0;
            end
            t_q          <= '0;
            sched_done_q <= 1'b0;
        end else begin
            sched_done_q <= last_beat;
            if (load) begin
                for (int k = 0; k < WINDOW; k++) begin
                    window_q[k] <= block_data[BLOCK_W-1-WORD_W*k -: WORD_W];
                end
                t_q <= '0;
            end else if (beat) begin
                for (int k = 0; k < WINDOW - 1; k++) begin
                    window_q[k] <= window_q[k+1];
                end
                window_q[WINDOW-1] <= w_next;
                if (t_q != LAST_T) begin
                    t_q <= t_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: hand-computed words plus an independent
// schedule model feeding an expected-word queue.
module tb_sha256_msg_schedule;
    import sha256_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               block_valid;
    logic [511:0]       block_data;
    logic               block_ready;
    logic               w_valid;
    logic               w_ready;
    logic [31:0]        w_data;
    logic [5:0]         w_index;
    logic               w_last;
    logic               sched_done;
    sched_state_e       sched_state;

    int                 errors = 0;
    int                 checks = 0;
    logic [31:0]        exp_q [$];
    logic [31:0]        got_w [64];

    logic [511:0]       blk_abc;
    logic [511:0]       blk_zero;
    logic [511:0]       blk_ones;
    logic [511:0]       blk_pat;

    sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .block_valid (block_valid),
        .block_data  (block_data),
        .block_ready (block_ready),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .w_index     (w_index),
        .w_last      (w_last),
        .sched_done  (sched_done),
        .sched_state (sched_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Scoreboard model: full 64-word expansion, pushed into the expected queue.
    task automatic push_expected(input logic [511:0] blk);
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
    endtask

    task automatic feed_block(input logic [511:0] blk);
        int n = 0;
        block_data  = blk;
        block_valid = 1'b1;
        while (!block_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("ready_wait", 32'(block_ready), 32'd1);
        push_expected(blk);
        @(posedge clock); #1;
        block_valid = 1'b0;
        block_data  = {16{$urandom()}};
        check("first_valid", 32'(w_valid), 32'd1);
        check("first_index", 32'(w_index), 32'd0);
        check("busy_ready", 32'(block_ready), 32'd0);
    endtask

    task automatic consume(input int pct, input int start, input int n, input bit tail);
        int          beats = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] hold_d = '0;
        logic [5:0]  hold_i = '0;
        logic [31:0] exp_w;
        while (beats < n && cyc < 4000) begin
            if (stalled) begin
                check("stall_valid", 32'(w_valid), 32'd1);
                check("stall_data", w_data, hold_d);
                check("stall_index", 32'(w_index), 32'(hold_i));
            end
            w_ready = ($urandom_range(0, 99) < pct);
            if (w_valid && w_ready) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                check("w_data", w_data, exp_w);
                check("w_index", 32'(w_index), 32'(start + beats));
                check("w_last", 32'(w_last), 32'((start + beats) == 63));
                check("done_early", 32'(sched_done), 32'd0);
                got_w[start+beats] = w_data;
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = w_valid;
                hold_d  = w_data;
                hold_i  = w_index;
            end
            @(posedge clock); #1;
            cyc++;
        end
        w_ready = 1'b0;
        check("beat_count", 32'(beats), 32'(n));
        if (tail) begin
            check("done_pulse", 32'(sched_done), 32'd1);
            check("done_valid", 32'(w_valid), 32'd0);
            check("done_ready", 32'(block_ready), 32'd1);
            @(posedge clock); #1;
            check("done_once", 32'(sched_done), 32'd0);
        end
    endtask

    initial begin
        int          accepts;
        int          last_acc;
        bit          sel;
        logic [31:0] exp_w;

        blk_abc  = {32'h61626380, 448'h0, 32'h00000018};
        blk_zero = '0;
        blk_ones = '1;
        for (int k = 0; k < 16; k++) blk_pat[511-32*k -: 32] = 32'h11111111 * (k + 1);

        // Clock/reset
        reset       = 1'b1;
        block_valid = 1'b0;
        block_data  = '0;
        w_ready     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 32'(block_ready), 32'd1);
        check("rst_valid", 32'(w_valid), 32'd0);
        check("rst_data", w_data, 32'h0);
        check("rst_index", 32'(w_index), 32'd0);
        check("rst_last", 32'(w_last), 32'd0);
        check("rst_done", 32'(sched_done), 32'd0);
        check("rst_state", 32'(sched_state), 32'(SCHED_IDLE));
        reset = 1'b0;
        @(posedge clock); #1;

        // 1: "abc" block, w_ready held high
        feed_block(blk_abc);
        consume(100, 0, 64, 1'b1);
        check("abc_w0", got_w[0], 32'h61626380);
        check("abc_w15", got_w[15], 32'h00000018);
        check("abc_w16", got_w[16], 32'h61626380);
        check("abc_w17", got_w[17], 32'h000F0000);
        check("abc_w18", got_w[18], 32'h7DA86405);
        check("abc_w63", got_w[63], 32'h12B1EDEB);

        // 2: all-zero block
        feed_block(blk_zero);
        consume(100, 0, 64, 1'b1);

        // 3: "abc" under 50% backpressure
        feed_block(blk_abc);
        consume(50, 0, 64, 1'b1);
        check("bp_w63", got_w[63], 32'h12B1EDEB);

        // 4: reset at index 30 of block A, then block B
        feed_block(blk_abc);
        consume(100, 0, 30, 1'b0);
        check("pre_rst_index", 32'(w_index), 32'd30);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rst_ready", 32'(block_ready), 32'd1);
        check("mid_rst_valid", 32'(w_valid), 32'd0);
        check("mid_rst_data", w_data, 32'h0);
        check("mid_rst_index", 32'(w_index), 32'd0);
        check("mid_rst_last", 32'(w_last), 32'd0);
        check("mid_rst_done", 32'(sched_done), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        feed_block(blk_pat);
        check("b_w0", w_data, 32'h11111111);
        consume(100, 0, 64, 1'b1);

        // 5: block_valid held high with alternating blocks
        accepts     = 0;
        last_acc    = 0;
        sel         = 1'b0;
        block_valid = 1'b1;
        block_data  = blk_abc;
        w_ready     = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (w_valid) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                check("alt_data", w_data, exp_w);
            end
            if (block_valid && block_ready) begin
                check("alt_accept_idle", 32'(w_valid), 32'd0);
                if (accepts > 0) check("alt_period", 32'(cyc - last_acc), 32'd65);
                last_acc = cyc;
                accepts++;
                push_expected(block_data);
                @(posedge clock); #1;
                sel        = ~sel;
                block_data = sel ? blk_pat : blk_abc;
            end else begin
                @(posedge clock); #1;
            end
        end
        block_valid = 1'b0;
        check("alt_accepts", 32'(accepts), 32'd4);
        check("alt_index", 32'(w_index), 32'd4);
        consume(100, 4, 60, 1'b1);

        // 6: all-ones block exercises carry drop
        feed_block(blk_ones);
        consume(100, 0, 64, 1'b1);
        check("ones_w16", got_w[16], 32'h203FFFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
